// File: rtl/prbs_checker.sv
// PRBS checker: hunts for a self-consistent LFSR run, locks after LOCK_CNT predicted
// words, then flywheels its own prediction and counts mismatches until lock is lost.
module prbs_checker #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'b10111000,
  parameter int               LOCK_CNT   = 4,
  parameter int               UNLOCK_CNT = 4,
  parameter int               ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clr,
  output logic             o_locked,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     pred_reg;
  logic                 pred_vld_reg;
  logic [MATCH_W-1:0]   match_reg;
  logic [MISS_W-1:0]    miss_reg;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  logic [WIDTH-1:0]   data_next;
  logic [WIDTH-1:0]   pred_next;
  logic [MATCH_W-1:0] match_next;
  logic [MISS_W-1:0]  miss_next;
  logic               hit;
  logic               zero_word;
  logic               err_sat;

  always_comb begin
    data_next  = lfsr_next(i_data);
    pred_next  = lfsr_next(pred_reg);
    match_next = match_reg + MATCH_W'(1);
    miss_next  = miss_reg + MISS_W'(1);
    hit        = (i_data == pred_reg);
    zero_word  = (i_data == '0);
    err_sat    = &o_err_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= HUNT;
      pred_reg     <= '0;
      pred_vld_reg <= 1'b0;
      match_reg    <= '0;
      miss_reg     <= '0;
      o_locked     <= 1'b0;
      o_err        <= 1'b0;
      o_err_cnt    <= '0;
    end else begin
      o_err <= 1'b0;
      if (i_clr)
        o_err_cnt <= '0;

      if (i_valid) begin
        case (state_reg)
          HUNT: begin
            // All-zero is the LFSR's lock-up state, so it can never seed a run.
            if (zero_word) begin
              pred_reg     <= data_next;
              pred_vld_reg <= 1'b0;
              match_reg    <= '0;
            end else if (pred_vld_reg && hit) begin
              pred_reg  <= data_next;
              match_reg <= match_next;
              if (match_next == MATCH_W'(LOCK_CNT)) begin
                state_reg <= LOCKED;
                miss_reg  <= '0;
                o_locked  <= 1'b1;
              end
            end else begin
              pred_reg     <= data_next;
              pred_vld_reg <= 1'b1;
              match_reg    <= '0;
            end
          end

          LOCKED: begin
            pred_reg <= pred_next;
            if (hit) begin
              miss_reg <= '0;
            end else begin
              o_err    <= 1'b1;
              miss_reg <= miss_next;
              // A clear coinciding with an error keeps that error in the count.
              if (i_clr)
                o_err_cnt <= ERR_W'(1);
              else if (!err_sat)
                o_err_cnt <= o_err_cnt + ERR_W'(1);
              if (miss_next == MISS_W'(UNLOCK_CNT)) begin
                state_reg    <= HUNT;
                pred_vld_reg <= 1'b0;
                match_reg    <= '0;
                o_locked     <= 1'b0;
              end
            end
          end

          default: state_reg <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: default instance plus a small-counter instance
// (ERR_W=2, UNLOCK_CNT=8) used for saturation and clear-with-error behaviour.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_clr = 1'b0;
  logic       o_locked;
  logic       o_err;
  logic [15:0] o_err_cnt;

  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_clr = 1'b0;
  logic       s_locked;
  logic       s_err;
  logic [1:0] s_err_cnt;

  int total = 0;
  int bad   = 0;

  // Hand-computed sequence for taps 0xB8, starting at 0x01.
  logic [7:0] seq [0:18];

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_clr(i_clr),
    .o_locked(o_locked), .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  prbs_checker #(.ERR_W(2), .UNLOCK_CNT(8)) dut_sat (
    .clk(clk), .rst(rst), .i_valid(s_valid), .i_data(s_data), .i_clr(s_clr),
    .o_locked(s_locked), .o_err(s_err), .o_err_cnt(s_err_cnt)
  );

  // Called at posedge+1; drives one word and returns at the following posedge+1.
  task automatic send(input logic [7:0] d, input logic clr);
    i_valid = 1'b1; i_data = d; i_clr = clr;
    @(posedge clk); #1;
    i_valid = 1'b0; i_clr = 1'b0;
    $display("tx main data=%h clr=%b locked=%b err=%b cnt=%0d", d, clr, o_locked, o_err, o_err_cnt);
  endtask

  task automatic send_sat(input logic [7:0] d, input logic clr);
    s_valid = 1'b1; s_data = d; s_clr = clr;
    @(posedge clk); #1;
    s_valid = 1'b0; s_clr = 1'b0;
    $display("tx sat data=%h clr=%b locked=%b err=%b cnt=%0d", d, clr, s_locked, s_err, s_err_cnt);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    $display("tx main idle locked=%b err=%b cnt=%0d", o_locked, o_err, o_err_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", o_locked); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", o_err); end
    total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", o_err_cnt); end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_lock_acquire();
    for (int i = 0; i < 5; i++) begin
      send(seq[i], 1'b0);
      total++;
      if (o_locked !== (i == 4)) begin bad++; $display("FAIL lock_acq_locked word=%0d got=%b want=%b", i, o_locked, (i == 4)); end
      total++;
      if (o_err !== 1'b0) begin bad++; $display("FAIL lock_acq_err word=%0d got=%b want=0", i, o_err); end
    end
    total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL lock_acq_cnt got=%0d want=0", o_err_cnt); end
  endtask

  task automatic test_flywheel();
    send(8'h22, 1'b0);  // expected 0x23
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL fly_err got=%b want=1", o_err); end
    total++; if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL fly_cnt got=%0d want=1", o_err_cnt); end
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL fly_locked got=%b want=1", o_locked); end
    for (int i = 6; i <= 10; i++) begin
      send(seq[i], 1'b0);
      total++;
      if (o_err !== 1'b0 || o_locked !== 1'b1) begin
        bad++; $display("FAIL fly_cont word=%h err=%b locked=%b want err=0 locked=1", seq[i], o_err, o_locked);
      end
    end
    total++; if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL fly_cnt_end got=%0d want=1", o_err_cnt); end
  endtask

  task automatic test_gaps();
    for (int i = 11; i <= 14; i++) begin
      send(seq[i], 1'b0);
      total++;
      if (o_err !== 1'b0 || o_locked !== 1'b1) begin
        bad++; $display("FAIL gap_word word=%h err=%b locked=%b want err=0 locked=1", seq[i], o_err, o_locked);
      end
      for (int g = 0; g < 2; g++) begin
        idle();
        total++;
        if (o_err !== 1'b0 || o_locked !== 1'b1 || o_err_cnt !== 16'd1) begin
          bad++; $display("FAIL gap_idle err=%b locked=%b cnt=%0d want err=0 locked=1 cnt=1", o_err, o_locked, o_err_cnt);
        end
      end
    end
  endtask

  // Four wrong words against flywheel predictions 0x25,0x4B,0x97,0x2E, then relock.
  task automatic test_back_to_back();
    logic [7:0] wrong [0:3];
    wrong[0] = 8'h00; wrong[1] = 8'hFF; wrong[2] = 8'h55; wrong[3] = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      send(wrong[i], 1'b0);
      total++; if (o_err !== 1'b1) begin bad++; $display("FAIL loss_err word=%0d got=%b want=1", i, o_err); end
      total++; if (o_err_cnt !== 16'(i + 2)) begin bad++; $display("FAIL loss_cnt word=%0d got=%0d want=%0d", i, o_err_cnt, i + 2); end
      total++; if (o_locked !== (i != 3)) begin bad++; $display("FAIL loss_locked word=%0d got=%b want=%b", i, o_locked, (i != 3)); end
    end
    for (int i = 0; i < 5; i++) begin
      send(seq[i + 8], 1'b0);
      total++;
      if (o_locked !== (i == 4) || o_err !== 1'b0) begin
        bad++; $display("FAIL relock word=%0d locked=%b err=%b want locked=%b err=0", i, o_locked, o_err, (i == 4));
      end
    end
    total++; if (o_err_cnt !== 16'd5) begin bad++; $display("FAIL relock_cnt got=%0d want=5", o_err_cnt); end
  endtask

  task automatic test_zero_hunt();
    rst = 1'b1; #2; rst = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      send(8'h00, 1'b0);
      total++;
      if (o_locked !== 1'b0 || o_err !== 1'b0) begin
        bad++; $display("FAIL zero_hunt word=%0d locked=%b err=%b want 0 0", i, o_locked, o_err);
      end
    end
    for (int i = 0; i < 5; i++) send(seq[i], 1'b0);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL zero_then_lock got=%b want=1", o_locked); end
  endtask

  task automatic test_clear();
    send(8'h00, 1'b0);  // expected 0x23
    total++; if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL clr_pre got=%0d want=1", o_err_cnt); end
    i_clr = 1'b1; idle(); i_clr = 1'b0;
    total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL clr_only got=%0d want=0", o_err_cnt); end
    send(seq[6], 1'b0);
    send(8'h00, 1'b0);  // expected 0x8E
    total++; if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL clr_post got=%0d want=1", o_err_cnt); end
  endtask

  task automatic test_saturation();
    logic [7:0] wrong [0:4];
    logic [1:0] want_cnt [0:4];
    wrong[0] = 8'h00; wrong[1] = 8'hFF; wrong[2] = 8'h55; wrong[3] = 8'hAA; wrong[4] = 8'h00;
    want_cnt[0] = 2'd1; want_cnt[1] = 2'd2; want_cnt[2] = 2'd3; want_cnt[3] = 2'd3; want_cnt[4] = 2'd3;
    for (int i = 0; i < 5; i++) send_sat(seq[i], 1'b0);
    total++; if (s_locked !== 1'b1) begin bad++; $display("FAIL sat_lock got=%b want=1", s_locked); end
    for (int i = 0; i < 5; i++) begin
      send_sat(wrong[i], 1'b0);
      total++;
      if (s_err_cnt !== want_cnt[i] || s_err !== 1'b1 || s_locked !== 1'b1) begin
        bad++; $display("FAIL sat_cnt word=%0d cnt=%0d err=%b locked=%b want cnt=%0d err=1 locked=1",
                        i, s_err_cnt, s_err, s_locked, want_cnt[i]);
      end
    end
    send_sat(8'hFF, 1'b1);
    total++; if (s_err_cnt !== 2'd1) begin bad++; $display("FAIL sat_clr_err got=%0d want=1", s_err_cnt); end
    total++; if (s_err !== 1'b1) begin bad++; $display("FAIL sat_clr_pulse got=%b want=1", s_err); end
  endtask

  // Main instance is locked with cnt=1; predictions continue from 0x1C.
  task automatic test_async_reset();
    send(8'h00, 1'b0);  // expected 0x1C, leaves o_err high
    #2 rst = 1'b1;
    #1;
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL async_locked got=%b want=0", o_locked); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL async_err got=%b want=0", o_err); end
    total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL async_cnt got=%0d want=0", o_err_cnt); end
    #1 rst = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      send(seq[i + 10], 1'b0);
      total++;
      if (o_locked !== (i == 4)) begin bad++; $display("FAIL async_relock word=%0d got=%b want=%b", i, o_locked, (i == 4)); end
    end
  endtask

  initial begin
    seq[0]  = 8'h01; seq[1]  = 8'h02; seq[2]  = 8'h04; seq[3]  = 8'h08;
    seq[4]  = 8'h11; seq[5]  = 8'h23; seq[6]  = 8'h47; seq[7]  = 8'h8E;
    seq[8]  = 8'h1C; seq[9]  = 8'h38; seq[10] = 8'h71; seq[11] = 8'hE2;
    seq[12] = 8'hC4; seq[13] = 8'h89; seq[14] = 8'h12; seq[15] = 8'h25;
    seq[16] = 8'h4B; seq[17] = 8'h97; seq[18] = 8'h2E;

    test_reset();
    test_lock_acquire();
    test_flywheel();
    test_gaps();
    test_back_to_back();
    test_zero_hunt();
    test_clear();
    test_saturation();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
